// File: rtl/eth_pkg.sv
// Shared Ethernet constants, tuser field layout and framer state encoding.
package eth_pkg;

  localparam int unsigned HEADER_LEN         = 14;
  localparam int unsigned ETH_MIN_FRAME_LEN  = 60;
  localparam logic [47:0] BROADCAST_MAC_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;

  localparam int unsigned DST_MAC_LSB   = 0;
  localparam int unsigned ETHERTYPE_LSB = 48;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StPad
  } framer_state_e;

endpackage

// File: rtl/eth_framer.sv
// Transmit-side Ethernet II framer: prepends dst/src MAC and EtherType to an
// 8-bit payload stream and zero-pads short frames up to the minimum length.
module eth_framer
  import eth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter logic [47:0] SRC_MAC_ADDR  = 48'h1122_3344_5566,
  parameter int unsigned MIN_FRAME_LEN = ETH_MIN_FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [63:0]           s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           frames_sent,
  output logic                  busy
);

  localparam logic [6:0] HdrLast = 7'(HEADER_LEN - 1);
  localparam logic [6:0] MinLen  = 7'(MIN_FRAME_LEN);
  localparam logic [6:0] PadLast = 7'(MIN_FRAME_LEN - 1);

  framer_state_e state_q;
  logic [6:0]    frame_cnt_q;
  logic [47:0]   dst_mac_q;
  logic [15:0]   ethertype_q;
  logic [15:0]   frames_sent_q;

  logic [6:0] cnt_inc;
  logic       min_reached;
  logic [6:0] cnt_sat;
  logic       out_xfer;

  function automatic logic [7:0] header_byte(input logic [3:0] idx);
    logic [8*HEADER_LEN-1:0] hdr;
    hdr = {dst_mac_q, SRC_MAC_ADDR, ethertype_q};
    return hdr[8*(HEADER_LEN-1-int'(idx)) +: 8];
  endfunction

  // frame_cnt counts every output byte (header included), so it doubles as header index.
  assign cnt_inc     = frame_cnt_q + 7'd1;
  assign min_reached = cnt_inc >= MinLen;
  assign cnt_sat     = min_reached ? MinLen : cnt_inc;
  assign out_xfer    = m_axis_tvalid && m_axis_tready;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state_q)
      StIdle: ;
      StHeader: begin
        m_axis_tdata  = header_byte(frame_cnt_q[3:0]);
        m_axis_tvalid = 1'b1;
      end
      StPayload: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast && min_reached;
        s_axis_tready = m_axis_tready;
      end
      StPad: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = frame_cnt_q == PadLast;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      frame_cnt_q   <= '0;
      dst_mac_q     <= '0;
      ethertype_q   <= '0;
      frames_sent_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_axis_tvalid) begin
            dst_mac_q   <= s_axis_tuser[DST_MAC_LSB +: 48];
            ethertype_q <= s_axis_tuser[ETHERTYPE_LSB +: 16];
            frame_cnt_q <= '0;
            state_q     <= StHeader;
          end
        end
        StHeader: begin
          if (out_xfer) begin
            frame_cnt_q <= cnt_inc;
            if (frame_cnt_q == HdrLast) state_q <= StPayload;
          end
        end
        StPayload: begin
          if (out_xfer) begin
            frame_cnt_q <= cnt_sat;
            if (s_axis_tlast) begin
              if (min_reached) begin
                frames_sent_q <= frames_sent_q + 16'd1;
                state_q       <= StIdle;
              end else begin
                state_q <= StPad;
              end
            end
          end
        end
        StPad: begin
          if (out_xfer) begin
            frame_cnt_q <= cnt_sat;
            if (frame_cnt_q == PadLast) begin
              frames_sent_q <= frames_sent_q + 16'd1;
              state_q       <= StIdle;
            end
          end
        end
      endcase
    end
  end

  assign frames_sent = frames_sent_q;
  assign busy        = state_q != StIdle;

endmodule

// File: tb/tb_eth_framer.sv
// Directed bench for eth_framer: expected frame bytes are queued as stimulus is
// issued and compared as the framer emits them.
module tb_eth_framer;
  import eth_pkg::*;

  localparam logic [47:0] SrcMac  = 48'h1122_3344_5566;
  localparam int          Timeout = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [63:0] s_axis_tuser;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] frames_sent;
  logic        busy;

  int          vectors     = 0;
  int          miscompares = 0;
  int          out_cnt     = 0;
  int          ready_mode  = 0;
  logic [15:0] frames_exp  = 16'd0;
  logic [8:0]  exp_q[$];

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_last;

  eth_framer #(
    .DATA_WIDTH   (8),
    .SRC_MAC_ADDR (SrcMac),
    .MIN_FRAME_LEN(60)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frames_sent  (frames_sent),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: predicts the transfer at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
              {1'b1, prev_last, prev_data});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {m_axis_tlast, m_axis_tdata}, 64'h1ff);
        end else begin
          check($sformatf("out_byte_%0d", out_cnt), {m_axis_tlast, m_axis_tdata},
                exp_q.pop_front());
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Sink readiness: 0 = always ready, 1 = alternate 1,0,..., 2 = random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  task automatic push_expected(input logic [63:0] tuser, input int len, input logic [7:0] base);
    logic [111:0] hdr;
    logic [7:0]   b;
    int           total;
    hdr   = {tuser[47:0], SrcMac, tuser[63:48]};
    total = (14 + len < 60) ? 60 : 14 + len;
    for (int i = 0; i < total; i++) begin
      if (i < 14)            b = hdr[8*(13-i) +: 8];
      else if (i < 14 + len) b = base + 8'(i - 14);
      else                   b = 8'h00;
      exp_q.push_back({i == total - 1, b});
    end
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l);
    int   n    = 0;
    logic done = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > Timeout) begin
        check("beat_timeout", 64'(n), 64'(Timeout));
        done = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] tuser, input int len, input logic [7:0] base,
                            input bit gaps, input bit lat_chk);
    push_expected(tuser, len, base);
    s_axis_tuser = tuser;
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      if (i == 0 && lat_chk) begin
        s_axis_tdata  = base;
        s_axis_tlast  = (len == 1);
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        check("idle_outputs", {m_axis_tvalid, s_axis_tready, busy}, 3'b000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("first_hdr_latency", {m_axis_tvalid, s_axis_tready, busy}, 3'b101);
        @(posedge clk);
        #1;
      end
      drive_beat(base + 8'(i), i == len - 1);
      // tuser must be ignored once the frame has started
      if (i == 0) s_axis_tuser = {$urandom(), $urandom()};
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < Timeout) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_frames_sent"}, 64'(frames_sent), 64'(frames_exp));
  endtask

  initial begin
    int start;
    int n;
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, frames_sent},
          {4'b0000, 16'h0000});
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 50-byte payload, broadcast IPv4, no backpressure
    send_frame({ETHERTYPE_IPV4, BROADCAST_MAC_ADDR}, 50, 8'h00, 1'b0, 1'b1);
    frames_exp++;
    wait_idle("frame50");

    // short payload gets padded; input tlast must not leak out at byte 24
    send_frame({16'h86DD, 48'h0200_0000_0001}, 10, 8'h80, 1'b0, 1'b1);
    frames_exp++;
    wait_idle("frame10");

    // exactly minimum length
    send_frame({ETHERTYPE_IPV4, 48'h0200_0000_0002}, 46, 8'h10, 1'b0, 1'b1);
    frames_exp++;
    wait_idle("frame46");

    // alternating backpressure with random source gaps
    ready_mode = 1;
    send_frame({ETHERTYPE_IPV4, BROADCAST_MAC_ADDR}, 50, 8'h00, 1'b1, 1'b0);
    frames_exp++;
    wait_idle("frame50_stall");

    // single-byte payload under random backpressure
    ready_mode = 2;
    send_frame({16'h88B5, 48'h0200_0000_0003}, 1, 8'hC5, 1'b1, 1'b0);
    frames_exp++;
    wait_idle("frame1");

    // long payload: counter saturates, no truncation
    send_frame({ETHERTYPE_IPV4, 48'h0200_0000_0004}, 70, 8'h20, 1'b1, 1'b0);
    frames_exp++;
    wait_idle("frame70");

    // back-to-back frames with different tuser
    ready_mode = 0;
    send_frame({ETHERTYPE_IPV4, BROADCAST_MAC_ADDR}, 20, 8'h30, 1'b0, 1'b0);
    send_frame({16'h0806, 48'h0A0B_0C0D_0E0F}, 28, 8'h60, 1'b0, 1'b0);
    frames_exp += 16'd2;
    wait_idle("back_to_back");

    // reset after five header bytes
    push_expected({ETHERTYPE_IPV4, 48'h0200_0000_0005}, 10, 8'h40);
    s_axis_tuser  = {ETHERTYPE_IPV4, 48'h0200_0000_0005};
    s_axis_tdata  = 8'h40;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    start = out_cnt;
    n     = 0;
    while (out_cnt - start < 5 && n < Timeout) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hdr_bytes_before_rst", 64'(out_cnt - start), 64'd5);
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    frames_exp = 16'd0;
    @(negedge clk);
    check("after_mid_rst", {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, frames_sent},
          {4'b0000, 16'h0000});
    @(posedge clk);
    #1;
    send_frame({16'h0806, 48'h0A0B_0C0D_0E0F}, 10, 8'hA0, 1'b0, 1'b1);
    frames_exp++;
    wait_idle("after_rst_frame");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
